// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction-fetch front end: opcode, FSM encodings
// and the JAL immediate extractor used by the static next-PC predictor.
package ifetch_pkg;

   localparam logic [6:0] OPCODE_JAL = 7'b1101111;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;  // free to issue a request
   localparam logic [1:0] ST_WAIT = 2'd1;  // one request outstanding, response kept
   localparam logic [1:0] ST_DROP = 2'd2;  // one request outstanding, response discarded

   localparam int JAL_IMM_W = 21;

   // Reassembles the scrambled J-type immediate (bit 0 is always zero).
   function automatic logic [JAL_IMM_W-1:0] jal_imm(input logic [31:0] inst);
      return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Circular FIFO holding packed fetch entries between the fetch FSM and the
// decoder. Flush empties it in one cycle; pointers wrap modulo DEPTH.
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 96
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    head_q;
   logic [PW-1:0]    tail_q;
   logic [PW:0]      count_q;
   logic             pop_ok;

   assign pop_ok = pop && (count_q != '0);

   // Storage, pointers and occupancy; frozen whenever en is low.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         // NOTE: the storage is reset too so the head outputs are defined
         // (zero) after reset; the array is only IQ_DEPTH entries deep.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (en) begin
         if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (push) begin
               mem_q[tail_q] <= push_data;
               tail_q        <= tail_q + 1'b1;
            end
            if (pop_ok) head_q <= head_q + 1'b1;
            case ({push, pop_ok})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: count_q <= count_q;
            endcase
         end
      end
   end

   assign head_data = mem_q[head_q];
   assign count     = count_q;
   assign empty     = (count_q == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one I-cache request
// at a time, predicts the next PC (static JAL target or PC+4) and buffers
// fetched instructions for the decoder. A redirect flushes and restarts fetch.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter int               ILEN     = 32,
   parameter int               IQ_DEPTH = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   output logic             ic_req_valid,
   output logic [XLEN-1:0]  ic_req_addr,
   input  logic             ic_resp_valid,
   input  logic [ILEN-1:0]  ic_resp_inst,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             if_valid,
   output logic [ILEN-1:0]  if_inst,
   output logic [XLEN-1:0]  if_pc,
   output logic [XLEN-1:0]  if_pred_pc,
   input  logic             dec_ready
);

   localparam int CW       = $clog2(IQ_DEPTH) + 1;
   localparam int ENT_W    = ILEN + 2 * XLEN;
   // Entry packing: {inst, pc, pred_pc}
   localparam int OFF_PRED = 0;
   localparam int OFF_PC   = XLEN;
   localparam int OFF_INST = 2 * XLEN;
   localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

   logic [1:0]             state_q, state_d;
   logic [XLEN-1:0]        pc_q, pc_d;
   logic [XLEN-1:0]        pred_pc;
   logic [JAL_IMM_W-1:0]   imm;
   logic [CW-1:0]          q_count;
   logic                   q_empty;
   logic [ENT_W-1:0]       q_head;
   logic                   push, pop, flush;

   // Static predictor: JAL target relative to the request PC, else PC+4.
   always_comb begin
      imm = jal_imm(ic_resp_inst[31:0]);
      if (ic_resp_inst[6:0] == OPCODE_JAL)
         pred_pc = pc_q + {{(XLEN-JAL_IMM_W){imm[JAL_IMM_W-1]}}, imm};
      else
         pred_pc = pc_q + XLEN'(4);
   end

   // A request only fires from IDLE with a free slot; that slot stays
   // reserved because occupancy can only fall while the request is in flight.
   assign ic_req_valid = !rst && rdy && (state_q == ST_IDLE) &&
                         (q_count < DEPTH_C) && !redirect_valid;
   assign ic_req_addr  = pc_q;

   assign push  = rdy && ic_resp_valid && (state_q == ST_WAIT) && !redirect_valid;
   assign pop   = rdy && !q_empty && dec_ready;
   assign flush = rdy && redirect_valid;

   // Next-state and next-PC; redirect overrides normal sequencing.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no
      // latch is inferred.
      state_d = state_q;
      pc_d    = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc;
         // A response arriving with the redirect is the outstanding one,
         // so nothing is left to drop.
         if (state_q != ST_IDLE) state_d = ic_resp_valid ? ST_IDLE : ST_DROP;
      end else begin
         case (state_q)
            ST_IDLE: if (ic_req_valid) state_d = ST_WAIT;
            ST_WAIT: if (ic_resp_valid) begin
               pc_d    = pred_pc;
               state_d = ST_IDLE;
            end
            ST_DROP: if (ic_resp_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FSM and PC registers; frozen while rdy is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
      end else if (rdy) begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   ifetch_queue #(
      .DEPTH (IQ_DEPTH),
      .WIDTH (ENT_W)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .en        (rdy),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .push_data ({ic_resp_inst, pc_q, pred_pc}),
      .head_data (q_head),
      .count     (q_count),
      .empty     (q_empty)
   );

   assign if_valid   = !q_empty;
   assign if_inst    = q_head[OFF_INST +: ILEN];
   assign if_pc      = q_head[OFF_PC   +: XLEN];
   assign if_pred_pc = q_head[OFF_PRED +: XLEN];

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by random
// traffic, all compared against a queue-based reference model of the fetch
// front end and a single-outstanding cache model with variable latency.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        ic_req_valid;
   logic [31:0] ic_req_addr;
   logic        ic_resp_valid;
   logic [31:0] ic_resp_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_inst, if_pc, if_pred_pc;
   logic        dec_ready;

   always #5 clk = ~clk;

   ifetch_unit #(
      .XLEN(32), .ILEN(32), .IQ_DEPTH(4), .RESET_PC(32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .ic_req_valid   (ic_req_valid),
      .ic_req_addr    (ic_req_addr),
      .ic_resp_valid  (ic_resp_valid),
      .ic_resp_inst   (ic_resp_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_pc          (if_pc),
      .if_pred_pc     (if_pred_pc),
      .dec_ready      (dec_ready)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model state
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pred;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_out;   // a request is in flight
   bit          m_drop;  // its response must be discarded

   // Cache model
   bit          c_pend;
   int          c_timer;
   int          c_lat = 1;
   bit          f_en = 1'b0;
   logic [31:0] f_inst = 32'h0;

   // Stimulus for the next cycle
   bit          s_rdy = 1'b1, s_redir = 1'b0, s_dec = 1'b1;
   logic [31:0] s_rpc = 32'h0;
   int          n_req = 0;

   function automatic logic [31:0] rand_inst();
      logic [31:0] v;
      v = $urandom();
      if ($urandom_range(0, 2) == 0) v[6:0] = 7'b1101111;
      else if (v[6:0] == 7'b1101111) v[0] = 1'b0;
      return v;
   endfunction

   // Next PC from the architectural meaning of JAL: pc + signed offset.
   function automatic logic [31:0] ref_pred(input logic [31:0] pc, input logic [31:0] inst);
      int off;
      if (inst[6:0] != 7'b1101111) return pc + 32'd4;
      off = int'({24'b0, inst[19:12]}) * 4096 + int'({31'b0, inst[20]}) * 2048 +
            int'({22'b0, inst[30:21]}) * 2;
      if (inst[31]) off = off - 1048576;
      return pc + 32'(off);
   endfunction

   task automatic do_reset();
      rst = 1'b1; rdy = 1'b1; ic_resp_valid = 1'b0; ic_resp_inst = '0;
      redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", ic_req_valid, 1'b0);
      check("rst_if_valid", if_valid, 1'b0);
      rst = 1'b0;
      mq.delete(); m_pc = 32'h0; m_out = 0; m_drop = 0; c_pend = 0; c_timer = 0;
   endtask

   // One cycle: drive at the negedge, check, advance the model, wait.
   task automatic cycle();
      bit          exp_req;
      logic [31:0] pred;
      rdy            = s_rdy;
      redirect_valid = s_redir;
      redirect_pc    = s_rpc;
      dec_ready      = s_dec;
      ic_resp_valid  = s_rdy && c_pend && (c_timer == 0);
      ic_resp_inst   = ic_resp_valid ? (f_en ? f_inst : rand_inst()) : 32'h0;
      #1;
      exp_req = s_rdy && !m_out && (mq.size() < 4) && !s_redir;
      check("req_valid", ic_req_valid, exp_req);
      if (exp_req) check("req_addr", ic_req_addr, m_pc);
      if (ic_req_valid) n_req++;
      check("if_valid", if_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         check("if_inst", if_inst, mq[0].inst);
         check("if_pc", if_pc, mq[0].pc);
         check("if_pred_pc", if_pred_pc, mq[0].pred);
      end
      if (s_rdy) begin
         if (s_dec && mq.size() > 0) void'(mq.pop_front());
         if (ic_resp_valid) begin
            if (!s_redir && !m_drop) begin
               pred = ref_pred(m_pc, ic_resp_inst);
               mq.push_back('{ic_resp_inst, m_pc, pred});
               m_pc = pred;
            end
            m_out = 0; m_drop = 0; c_pend = 0;
         end else if (c_pend) begin
            c_timer--;
         end
         if (s_redir) begin
            mq.delete();
            m_pc = s_rpc;
            if (m_out) m_drop = 1;
         end
         if (exp_req) begin
            m_out = 1; c_pend = 1; c_timer = c_lat - 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      s_redir = 1'b1; s_rpc = pc;
      cycle();
      s_redir = 1'b0;
   endtask

   initial begin
      do_reset();

      // Plain fetch, latency 1, addi nop
      c_lat = 1; f_en = 1'b1; f_inst = 32'h0000_0013;
      s_rdy = 1'b1; s_dec = 1'b1;
      repeat (6) cycle();

      // Forward JAL at 0x100
      f_inst = 32'h0080_006F;
      redirect_to(32'h100);
      repeat (6) cycle();

      // Backward JAL at 0x0 wrapping below zero
      f_inst = 32'hFFDF_F06F;
      redirect_to(32'h0);
      repeat (6) cycle();

      // Fill the queue with the decoder stalled: exactly IQ_DEPTH requests
      f_en = 1'b0; s_dec = 1'b0;
      redirect_to(32'h1000);
      n_req = 0;
      repeat (20) cycle();
      check("fill_reqs", n_req, 4);
      n_req = 0;
      s_dec = 1'b1; cycle();
      s_dec = 1'b0; repeat (10) cycle();
      check("pop_refill_reqs", n_req, 1);

      // Redirect while a slow request is outstanding
      c_lat = 3; s_dec = 1'b1;
      redirect_to(32'h400);
      for (int i = 0; i < 20 && !(m_out && !m_drop); i++) cycle();
      redirect_to(32'h200);
      repeat (8) cycle();

      // Freeze for 5 cycles with entries queued
      s_dec = 1'b0; c_lat = 1;
      repeat (6) cycle();
      s_rdy = 1'b0;
      repeat (5) begin
         s_dec = ($urandom_range(0, 1) == 1);
         cycle();
      end
      s_rdy = 1'b1;
      repeat (8) cycle();

      // Random traffic with a reset in the middle
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         c_lat   = $urandom_range(1, 3);
         s_rdy   = ($urandom_range(0, 9) != 0);
         s_dec   = ($urandom_range(0, 1) == 1);
         s_redir = ($urandom_range(0, 29) == 0);
         s_rpc   = {$urandom_range(0, 32'hFFFF), 2'b00};
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
